// File: rtl/cnt4_tick_sequencer_pkg.sv
// Shared types and constants for the 4-bit tick sequencer.

package cnt4_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_e;

    localparam int unsigned CW         = 4;
    localparam int unsigned RATE_SHIFT = 2;

endpackage

// File: rtl/cnt4_tick_sequencer_if.sv
// Control strobes and display-side outputs of the tick sequencer.

interface cnt4_tick_sequencer_if;
    import cnt4_pkg::*;

    logic          start;
    logic          stop;
    logic          clear;
    logic          dir;
    logic [1:0]    div_sel;
    logic [CW-1:0] count;
    logic          tick;
    logic          wrap;
    logic          running;

    modport master (
        output start, stop, clear, dir, div_sel,
        input  count, tick, wrap, running
    );

    modport slave (
        input  start, stop, clear, dir, div_sel,
        output count, tick, wrap, running
    );

endinterface

// File: rtl/cnt4_tick_sequencer_tick_prescaler.sv
// Programmable prescaler: counts 0..period-1 while enabled, registered tick on terminal count.

module tick_prescaler #(
    parameter int unsigned PW = 6
) (
    input  logic          f_crystal,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [PW:0]   period_i,
    output logic          hit_o,
    output logic          tick_o
);

    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] last;
    logic          tick_q, tick_d;

    // period never exceeds 2^PW, so period-1 always fits in PW bits
    assign last  = PW'(period_i - (PW+1)'(1));
    assign hit_o = (cnt_q == last);

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (en_i && hit_o) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge f_crystal or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/cnt4_tick_sequencer.sv
// Run/pause/idle sequencer for the 4-bit display counter with programmable tick rate.
// Define CNT4_AUTO_STOP_EN to return to idle on every wrap.

module cnt4_tick_sequencer
    import cnt4_pkg::*;
#(
    parameter int unsigned DIV_BASE = 100000000
) (
    input  logic                  f_crystal,
    input  logic                  rst_n,
    cnt4_tick_sequencer_if.slave  seq_io
);

    localparam int unsigned PW = $clog2(DIV_BASE);
    localparam logic [PW:0] DivBaseW = (PW+1)'(DIV_BASE);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    div_q, div_d;
    logic          wrap_q, wrap_d;
    logic          running_q;
    logic [PW:0]   period;
    logic          pre_en, pre_clr, pre_hit, pre_tick;
    logic          wrap_now;

    assign period = DivBaseW >> (RATE_SHIFT * 32'(div_q));

    tick_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .f_crystal (f_crystal),
        .rst_n     (rst_n),
        .en_i      (pre_en),
        .clr_i     (pre_clr),
        .period_i  (period),
        .hit_o     (pre_hit),
        .tick_o    (pre_tick)
    );

    assign wrap_now = seq_io.dir ? (count_q == '1) : (count_q == '0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        wrap_d  = 1'b0;
        pre_en  = 1'b0;
        pre_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (seq_io.clear) begin
                    count_d = '0;
                    pre_clr = 1'b1;
                end else if (seq_io.start) begin
                    state_d = StRun;
                    div_d   = seq_io.div_sel;
                    pre_clr = 1'b1;
                end
            end
            StRun: begin
                if (seq_io.clear) begin
                    state_d = StIdle;
                    count_d = '0;
                    pre_clr = 1'b1;
                end else begin
                    pre_en = 1'b1;
                    if (seq_io.stop) begin
                        state_d = StPause;
                    end
                    if (pre_hit) begin
                        count_d = seq_io.dir ? count_q + CW'(1) : count_q - CW'(1);
                        wrap_d  = wrap_now;
`ifdef CNT4_AUTO_STOP_EN
                        if (wrap_now) begin
                            state_d = StIdle;
                            pre_clr = 1'b1;
                        end
`endif
                    end
                end
            end
            StPause: begin
                if (seq_io.clear) begin
                    state_d = StIdle;
                    count_d = '0;
                    pre_clr = 1'b1;
                end else if (seq_io.start) begin
                    // resume from the held prescaler value; div_q is kept
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
                pre_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge f_crystal or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            div_q     <= '0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            div_q     <= div_d;
            wrap_q    <= wrap_d;
            running_q <= (state_d == StRun);
        end
    end

    assign seq_io.count   = count_q;
    assign seq_io.tick    = pre_tick;
    assign seq_io.wrap    = wrap_q;
    assign seq_io.running = running_q;

endmodule

// File: tb/tb_cnt4_tick_sequencer.sv
// Directed self-checking bench for cnt4_tick_sequencer with DIV_BASE=64.

module tb_cnt4_tick_sequencer;

    logic f_crystal;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    cnt4_tick_sequencer_if bus ();

    cnt4_tick_sequencer #(
        .DIV_BASE (64)
    ) dut (
        .f_crystal (f_crystal),
        .rst_n     (rst_n),
        .seq_io    (bus)
    );

    initial begin
        f_crystal = 1'b0;
        forever #5 f_crystal = ~f_crystal;
    end

    task automatic step(input int n);
        repeat (n) @(negedge f_crystal);
    endtask

    // Assert the chosen strobes for exactly one rising edge; caller sits at a negedge.
    task automatic pulse(input logic s, input logic p, input logic c);
        bus.start = s;
        bus.stop  = p;
        bus.clear = c;
        @(negedge f_crystal);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        step(2);
        n_checks++;
        if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_checks++;
        if ({bus.tick, bus.wrap, bus.running} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b want 000", {bus.tick, bus.wrap, bus.running});
        end
        rst_n = 1'b1;
        step(1);
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.running !== 1'b0) begin n_fail++; $display("FAIL idle_stop_ignored running=%b want 0", bus.running); end
    endtask

    task automatic test_first_tick(input string tag);
        bus.div_sel = 2'd0;
        bus.dir     = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({bus.running, bus.count} !== {1'b1, 4'd0}) begin
            n_fail++; $display("FAIL %s_start got run=%b cnt=%0d want run=1 cnt=0", tag, bus.running, bus.count);
        end
        step(63);
        n_checks++;
        if ({bus.tick, bus.count} !== {1'b0, 4'd0}) begin
            n_fail++; $display("FAIL %s_pre63 got tick=%b cnt=%0d want 0/0", tag, bus.tick, bus.count);
        end
        step(1);
        n_checks++;
        if ({bus.tick, bus.count} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL %s_tick64 got tick=%b cnt=%0d want 1/1", tag, bus.tick, bus.count);
        end
        step(63);
        n_checks++;
        if ({bus.tick, bus.count} !== {1'b0, 4'd1}) begin
            n_fail++; $display("FAIL %s_pre127 got tick=%b cnt=%0d want 0/1", tag, bus.tick, bus.count);
        end
        step(1);
        n_checks++;
        if ({bus.tick, bus.count, bus.running} !== {1'b1, 4'd2, 1'b1}) begin
            n_fail++; $display("FAIL %s_tick128 got tick=%b cnt=%0d run=%b want 1/2/1", tag, bus.tick, bus.count, bus.running);
        end
        pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({bus.running, bus.count} !== {1'b0, 4'd0}) begin
            n_fail++; $display("FAIL %s_clear got run=%b cnt=%0d want 0/0", tag, bus.running, bus.count);
        end
    endtask

    task automatic test_wrap_up();
        bus.div_sel = 2'd2;
        bus.dir     = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        step(60);
        n_checks++;
        if ({bus.count, bus.wrap} !== {4'd15, 1'b0}) begin
            n_fail++; $display("FAIL wrap_pre got cnt=%0d wrap=%b want 15/0", bus.count, bus.wrap);
        end
        step(4);
        n_checks++;
        if ({bus.tick, bus.count, bus.wrap} !== {1'b1, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL wrap_edge got tick=%b cnt=%0d wrap=%b want 1/0/1", bus.tick, bus.count, bus.wrap);
        end
`ifdef CNT4_AUTO_STOP_EN
        n_checks++;
        if (bus.running !== 1'b0) begin n_fail++; $display("FAIL wrap_autostop_run got %b want 0", bus.running); end
`else
        n_checks++;
        if (bus.running !== 1'b1) begin n_fail++; $display("FAIL wrap_free_run got %b want 1", bus.running); end
`endif
        step(1);
        n_checks++;
        if (bus.wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse_len got %b want 0", bus.wrap); end
        step(3);
`ifdef CNT4_AUTO_STOP_EN
        n_checks++;
        if ({bus.tick, bus.count} !== {1'b0, 4'd0}) begin
            n_fail++; $display("FAIL wrap_after_stop got tick=%b cnt=%0d want 0/0", bus.tick, bus.count);
        end
`else
        n_checks++;
        if ({bus.tick, bus.count} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL wrap_continue got tick=%b cnt=%0d want 1/1", bus.tick, bus.count);
        end
`endif
        pulse(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_down_fast();
        bus.div_sel = 2'd3;
        bus.dir     = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({bus.tick, bus.count} !== {1'b0, 4'd0}) begin
            n_fail++; $display("FAIL down_start got tick=%b cnt=%0d want 0/0", bus.tick, bus.count);
        end
        step(1);
        n_checks++;
        if ({bus.tick, bus.count, bus.wrap} !== {1'b1, 4'd15, 1'b1}) begin
            n_fail++; $display("FAIL down_first got tick=%b cnt=%0d wrap=%b want 1/15/1", bus.tick, bus.count, bus.wrap);
        end
        step(1);
`ifdef CNT4_AUTO_STOP_EN
        n_checks++;
        if ({bus.tick, bus.count, bus.running} !== {1'b0, 4'd15, 1'b0}) begin
            n_fail++; $display("FAIL down_autostop got tick=%b cnt=%0d run=%b want 0/15/0", bus.tick, bus.count, bus.running);
        end
`else
        n_checks++;
        if ({bus.tick, bus.count, bus.wrap} !== {1'b1, 4'd14, 1'b0}) begin
            n_fail++; $display("FAIL down_second got tick=%b cnt=%0d wrap=%b want 1/14/0", bus.tick, bus.count, bus.wrap);
        end
        step(1);
        n_checks++;
        if ({bus.tick, bus.count} !== {1'b1, 4'd13}) begin
            n_fail++; $display("FAIL down_third got tick=%b cnt=%0d want 1/13", bus.tick, bus.count);
        end
`endif
        pulse(1'b0, 1'b0, 1'b1);
        bus.dir = 1'b1;
    endtask

    task automatic test_pause_resume();
        int ticks = 0;
        bus.div_sel = 2'd1;
        bus.dir     = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        step(9);
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({bus.running, bus.count} !== {1'b0, 4'd0}) begin
            n_fail++; $display("FAIL pause_enter got run=%b cnt=%0d want 0/0", bus.running, bus.count);
        end
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (bus.tick === 1'b1 || bus.count !== 4'd0) ticks++;
        end
        n_checks++;
        if (ticks !== 0) begin n_fail++; $display("FAIL pause_hold got %0d activity cycles want 0", ticks); end
        pulse(1'b1, 1'b0, 1'b0);
        step(5);
        n_checks++;
        if ({bus.running, bus.tick} !== {1'b1, 1'b0}) begin
            n_fail++; $display("FAIL resume_pre got run=%b tick=%b want 1/0", bus.running, bus.tick);
        end
        step(1);
        n_checks++;
        if ({bus.tick, bus.count} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL resume_tick6 got tick=%b cnt=%0d want 1/1", bus.tick, bus.count);
        end
        pulse(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clear_on_tick();
        bus.div_sel = 2'd2;
        pulse(1'b1, 1'b0, 1'b0);
        step(28);
        n_checks++;
        if ({bus.tick, bus.count} !== {1'b1, 4'd7}) begin
            n_fail++; $display("FAIL clr_setup got tick=%b cnt=%0d want 1/7", bus.tick, bus.count);
        end
        step(3);
        pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({bus.count, bus.tick, bus.wrap, bus.running} !== {4'd0, 3'b000}) begin
            n_fail++; $display("FAIL clr_on_tick got cnt=%0d tick=%b wrap=%b run=%b want 0/0/0/0",
                               bus.count, bus.tick, bus.wrap, bus.running);
        end
        pulse(1'b1, 1'b0, 1'b0);
        bus.div_sel = 2'd0;
        step(3);
        n_checks++;
        if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL divhold_pre got tick=%b want 0", bus.tick); end
        step(1);
        n_checks++;
        if ({bus.tick, bus.count} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL divhold_tick4 got tick=%b cnt=%0d want 1/1", bus.tick, bus.count);
        end
        step(4);
        n_checks++;
        if ({bus.tick, bus.count} !== {1'b1, 4'd2}) begin
            n_fail++; $display("FAIL divhold_tick8 got tick=%b cnt=%0d want 1/2", bus.tick, bus.count);
        end
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        step(4);
        n_checks++;
        if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL divnew_no_tick4 got tick=%b want 0", bus.tick); end
        step(60);
        n_checks++;
        if ({bus.tick, bus.count} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL divnew_tick64 got tick=%b cnt=%0d want 1/1", bus.tick, bus.count);
        end
        pulse(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        bus.div_sel = 2'd2;
        bus.dir     = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        step(36);
        n_checks++;
        if (bus.count !== 4'd9) begin n_fail++; $display("FAIL areset_setup got cnt=%0d want 9", bus.count); end
        step(2);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.count, bus.tick, bus.wrap, bus.running} !== {4'd0, 3'b000}) begin
            n_fail++; $display("FAIL areset_immediate got cnt=%0d tick=%b wrap=%b run=%b want 0/0/0/0",
                               bus.count, bus.tick, bus.wrap, bus.running);
        end
        @(negedge f_crystal);
        rst_n = 1'b1;
        step(1);
        test_first_tick("post_reset");
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.clear   = 1'b0;
        bus.dir     = 1'b1;
        bus.div_sel = 2'd0;
        test_reset();
        test_first_tick("first");
        test_wrap_up();
        test_down_fast();
        test_pause_resume();
        test_clear_on_tick();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt4_tick_sequencer.md
Name: cnt4_tick_sequencer

Overview:
Controller for the 4-bit up/down display counter and its prescaler.
- Owns a programmable prescaler that generates the count-enable tick from the board crystal clock.
- Runs a run/pause/idle FSM driven by start/stop/clear strobes from the board button logic.
- Drives the 4-bit count value, tick and wrap pulses, and a running flag to the LED/7-seg stage.
- Replaces ad-hoc free-running dividers: one block both sequences and configures the tick rate.

Parameters:
- DIV_BASE, 100000000: prescaler period in f_crystal cycles at div_sel=0. Must be a multiple of 64 and at least 64.
- PW, $clog2(DIV_BASE): prescaler width. Derived; not overridden.

Ports:
- f_crystal  in  1  board clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle strobe: start or resume counting.
- stop  in  1  single-cycle strobe: pause counting.
- clear  in  1  single-cycle strobe: return to idle and zero the count.
- dir  in  1  1 = count up, 0 = count down.
- div_sel  in  2  rate select; period = DIV_BASE >> (2*div_sel).
- count  out  4  counter value.
- tick  out  1  one-cycle pulse on each count update.
- wrap  out  1  one-cycle pulse on 15->0 (up) or 0->15 (down).
- running  out  1  high while the FSM is in RUN.

Behaviour:
- Reset: clock f_crystal; asynchronous, active-low reset rst_n.
  - state=IDLE, prescaler=0, div_q=0.
  - count=0, tick=0, wrap=0, running=0.
  - Reset asserted mid-operation aborts immediately, with no completion of the pending tick.
- All outputs are registered. running is exactly (state==RUN) after each edge.
- Strobe priority: clear > stop > start. Levels held for several cycles are treated as repeated strobes; this is harmless because transitions are idempotent.
- FSM states and transitions:
  - IDLE:
    - start -> RUN; prescaler<=0; div_q<=div_sel.
    - clear -> stay in IDLE; count<=0.
    - stop is ignored.
  - RUN:
    - Prescaler increments each cycle.
    - When prescaler == period(div_q)-1: prescaler<=0, tick<=1, and count<=count+1 if dir=1, else count-1, modulo 16. dir is sampled on that edge.
    - stop -> PAUSE; prescaler holds.
    - clear -> IDLE; count<=0; prescaler<=0.
  - PAUSE:
    - Prescaler and count hold.
    - start -> RUN, resuming from the held prescaler value; div_q is not reloaded.
    - clear -> IDLE; count<=0; prescaler<=0.
- div_sel is captured only on the IDLE->RUN transition. Changes during RUN or PAUSE take effect after the next clear+start.
- Simultaneous events:
  - tick + stop: the count update and tick pulse happen, then the FSM enters PAUSE.
  - tick + clear: clear wins; count=0, tick=0, wrap=0.
  - start in RUN is ignored.
- Timing:
  - tick and wrap are high in the same cycle that count first shows the new value.
  - First tick comes exactly period(div_q) cycles after the edge that sampled start.
  - With div_sel=3 and DIV_BASE=64, period=1 and tick is high on every RUN cycle.
- Prescaler width: compare against period-1 at PW bits; no overflow is possible because period <= DIV_BASE.

Optional Feature:
- Macro: CNT4_AUTO_STOP_EN.
- Defined:
  - On the edge that produces wrap, the FSM goes to IDLE and the prescaler is cleared.
  - running drops in the same cycle that wrap is high.
  - count keeps the wrapped value (0 going up, 15 going down).
  - A new start is required to continue counting.
- Undefined: count wraps modulo 16 and runs freely; wrap is informational only.

Decomposition:
- Package cnt4_pkg:
  - State encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
  - Count width constant CW=4.
  - Rate-shift constant RATE_SHIFT=2.
- Sub-module tick_prescaler:
  - Inputs: f_crystal, rst_n, en, clr, period.
  - Output: registered one-cycle tick.
  - Instantiated once.
- The FSM and count/wrap logic stay in the top module.

Test Plan:
- Reset, then start with DIV_BASE=64, div_sel=0, dir=1: first tick 64 cycles after start; count=1; ticks repeat every 64 cycles; running=1.
- div_sel=2 (period 4), dir=1, run 16 ticks: count returns to 0 with wrap=1 on the same cycle as the 15->0 update. With CNT4_AUTO_STOP_EN, running=0 on that same cycle and no further ticks occur.
- div_sel=3, dir=0 from count 0: tick every cycle; count goes 15,14,13; wrap on the first update only.
- Stop after 10 prescaler cycles at period 16, wait 50 cycles, then start: next tick exactly 6 cycles after the resume edge; count unchanged during the pause.
- Assert clear on the same edge as a tick while count=7: count=0, tick=0, state IDLE. Changing div_sel while running has no effect until clear+start.
- Drop rst_n asynchronously mid-period at count=9: count, tick, wrap and running go to 0 immediately without waiting for a clock edge. After release, start behaves as in the first scenario.
